// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//
// Keeps the program counter, drives a synchronous-read instruction memory,
// tracks the single request in flight and buffers returned words in a
// 2-entry queue that feeds decode over a valid/ready handshake. Execute can
// redirect the stream at any time; a redirect flushes everything queued or
// in flight.
//
// Configuration macro: FETCH_ALIGN_CHECK_EN
//   defined   - a redirect to a non word-aligned target raises a sticky fault
//               and stops fetch until an aligned redirect or reset.
//   undefined - redirect_pc_i[1:0] is ignored and fault_o is tied low.
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous active-high reset
//   imem_addr_o    byte address to instruction memory (straight from pc)
//   imem_data_i    word for the address sampled at the previous edge
//   out_valid_o    queue head holds an instruction
//   out_ready_i    decode accepts the head this cycle
//   out_instr_o    instruction at the queue head
//   out_pc_o       byte address of out_instr_o
//   redirect_i     flush and restart fetch at redirect_pc_i
//   redirect_pc_i  new fetch address
//   fault_o        misaligned redirect flag

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fault_o
);

  logic [31:0]      pc_q, pc_d;
  logic             pend_v_q, pend_v_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [1:0][31:0] fifo_pc_q;
  logic [1:0][31:0] fifo_instr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  logic             pop;
  logic             push;
  logic             wr_ptr;
  logic [2:0]       occ;
  logic             issue;
  logic             fault;
  logic             misalign;
  logic [31:0]      target;

  // Alignment handling of redirect targets.
`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign misalign = (redirect_pc_i[1:0] != 2'b00);
  assign target   = redirect_pc_i;
  assign fault    = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (redirect_i) begin
      fault_d = misalign;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
  assign misalign            = 1'b0;
  assign target              = {redirect_pc_i[31:2], 2'b00};
  assign fault               = 1'b0;
`endif

  assign pop    = (count_q != 2'd0) & out_ready_i;
  assign push   = pend_v_q;
  // Tail slot: the head when empty, the other slot when one entry is held.
  assign wr_ptr = rd_ptr_q ^ count_q[0];
  // Entries that will occupy the queue after this edge, counting the word
  // still in flight; issuing only below 2 means a push never hits a full queue.
  assign occ    = {1'b0, count_q} + {2'b00, pend_v_q} - {2'b00, pop};
  assign issue  = ~redirect_i & ~fault & (occ < 3'd2);

  always_comb begin
    pc_d      = pc_q;
    pend_v_d  = 1'b0;
    pend_pc_d = pend_pc_q;
    if (redirect_i) begin
      // A misaligned target leaves pc frozen while the fault is raised.
      if (!misalign) begin
        pc_d = target;
      end
    end else if (issue) begin
      pend_v_d  = 1'b1;
      pend_pc_d = pc_q;
      pc_d      = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      pend_v_q  <= 1'b0;
      pend_pc_q <= 32'h0;
    end else begin
      pc_q      <= pc_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_pc_q    <= '0;
      fifo_instr_q <= '0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else if (redirect_i) begin
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc_q[wr_ptr]    <= pend_pc_q;
        fifo_instr_q[wr_ptr] <= imem_data_i;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign imem_addr_o = pc_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_instr_o = fifo_instr_q[rd_ptr_q];
  assign out_pc_o    = fifo_pc_q[rd_ptr_q];
  assign fault_o     = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. The instruction memory returns 32'hA000_0000 + addr
// one edge after the address is sampled. Every fetch segment (after reset or
// a redirect) is an arithmetic stream start, start+4, ... so the expected
// delivery order is queued when the segment begins and popped by the
// monitor on each accepted handshake.

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IBASE    = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;

  int vectors     = 0;
  int miscompares = 0;
  int pops_seen   = 0;

  logic [31:0] exp_q[$];

  fetch_unit #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_addr_o  (imem_addr),
    .imem_data_i  (imem_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_instr_o  (out_instr),
    .out_pc_o     (out_pc),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .fault_o      (fault)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model.
  always @(posedge clk) imem_data <= IBASE + imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected delivery order of a fresh fetch segment.
  task automatic push_stream(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 1024; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // Called at posedge+1. Redirect is sampled at the next edge (E0); the
  // target must be the head right after E2 with out_valid low in between.
  task automatic do_redirect(input logic [31:0] target);
    logic [31:0] eff;
    eff         = target & ~32'h3;
    redirect    = 1'b1;
    redirect_pc = target;
    @(posedge clk);
    push_stream(eff);
    #1 redirect = 1'b0;
    chk("redir_valid_e0", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("redir_valid_e1", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("redir_valid_e2", {31'b0, out_valid}, 32'd1);
    chk("redir_head_pc", out_pc, eff);
  endtask

  // Monitor: scoreboard pops on handshakes, plus hold-stability while stalled.
  logic        prev_have = 1'b0;
  logic        prev_valid, prev_ready, prev_redirect;
  logic [31:0] prev_pc, prev_instr;
  logic [31:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_have = 1'b0;
    end else begin
      if (prev_have && prev_valid && !prev_ready && !prev_redirect) begin
        chk("stall_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_hold_pc", out_pc, prev_pc);
        chk("stall_hold_instr", out_instr, prev_instr);
      end
      if (out_valid && out_ready) begin
        pops_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got pc %h, expected nothing", out_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_pc", out_pc, mon_e);
          chk("sb_instr", out_instr, IBASE + mon_e);
        end
      end
      prev_have     = 1'b1;
      prev_valid    = out_valid;
      prev_ready    = out_ready;
      prev_redirect = redirect;
      prev_pc       = out_pc;
      prev_instr    = out_instr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        found;
    logic [31:0] t;

    rst         = 1'b1;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_fault", {31'b0, fault}, 32'd0);

    // Release: edge 1 issues, edge 2 pushes, valid from cycle 3.
    push_stream(RESET_PC);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("start_valid_c2", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("start_valid_c3", {31'b0, out_valid}, 32'd1);
    chk("start_pc", out_pc, RESET_PC);

    // Stall with pc 8 at the head.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_pc == 32'h8) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_pc8", {31'b0, found}, 32'd1);
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_pc", out_pc, 32'h8);
      chk("stall_instr", out_instr, IBASE + 32'h8);
    end
    chk("stall_imem_addr", imem_addr, 32'h10);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_pc12", out_pc, 32'hC);
    chk("release_valid12", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("release_pc16", out_pc, 32'h10);
    chk("release_valid16", {31'b0, out_valid}, 32'd1);

    // Redirect while two entries are queued.
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    do_redirect(32'h100);
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end

    // Wrap through the top of the address space.
    do_redirect(32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("wrap_pc_fffc", out_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_pc_0", out_pc, 32'h0);
    chk("wrap_instr_0", out_instr, IBASE);

    // Asynchronous reset mid-cycle while streaming.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_addr", imem_addr, RESET_PC);
    exp_q.delete();
    @(posedge clk);
    #3;
    push_stream(RESET_PC);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("restart_valid_c2", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("restart_valid_c3", {31'b0, out_valid}, 32'd1);
    chk("restart_pc", out_pc, RESET_PC);

`ifdef FETCH_ALIGN_CHECK_EN
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    @(posedge clk);
    exp_q.delete();
    #1 redirect = 1'b0;
    chk("misalign_fault", {31'b0, fault}, 32'd1);
    chk("misalign_valid", {31'b0, out_valid}, 32'd0);
    t = imem_addr;
    repeat (3) begin
      @(posedge clk); #1;
      chk("misalign_addr_frozen", imem_addr, t);
      chk("misalign_valid_low", {31'b0, out_valid}, 32'd0);
      chk("misalign_fault_sticky", {31'b0, fault}, 32'd1);
    end
    do_redirect(32'h200);
    chk("fault_cleared", {31'b0, fault}, 32'd0);
`else
    do_redirect(32'h102);
    chk("no_fault", {31'b0, fault}, 32'd0);
`endif

    // Randomized backpressure and redirects.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        t = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
        t[1:0] = 2'b00;
`endif
        do_redirect(t);
      end else begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end

    vectors++;
    if (pops_seen < 100) begin
      miscompares++;
      $display("FAIL handshake_count: got %0d, expected at least 100", pops_seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
